// File: rtl/sigmoid_share_arbiter_pkg.sv
// Shared GAN-datapath definitions: controller state encoding, fixed-point
// defaults and the width helper used for requester indices.
package ganmind_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned Q_FRAC     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_RESP
  } state_e;

  // ceil(log2(v)), never below 1 so a single requester still gets a 1-bit index
  function automatic int unsigned calc_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sigmoid_share_arbiter_if.sv
// Requester-side bus of the shared sigmoid engine: level requests with
// flattened vectors in, one-hot ack/completion pulses and the result out.
interface sigmoid_share_arbiter_if #(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned ELEMENT_COUNT = 128,
  parameter int unsigned DATA_WIDTH    = ganmind_pkg::DATA_WIDTH
);
  import ganmind_pkg::*;

  localparam int unsigned GW = calc_clog2(NUM_REQ);
  localparam int unsigned VW = DATA_WIDTH * ELEMENT_COUNT;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*VW-1:0] req_data;
  logic [NUM_REQ-1:0]    ack;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [VW-1:0]         resp_data;
  logic                  busy;
  logic [GW-1:0]         grant_id;

  modport master (
    output req, req_data,
    input  ack, resp_valid, resp_data, busy, grant_id
  );

  modport slave (
    input  req, req_data,
    output ack, resp_valid, resp_data, busy, grant_id
  );

endinterface

// File: rtl/sigmoid_share_arbiter_vector_sigmoid.sv
// Vector sigmoid engine: piecewise-linear (PLAN) approximation, one element
// per cycle after start, done pulses the cycle after the last element.
module vector_sigmoid #(
  parameter int unsigned ELEMENT_COUNT = 128,
  parameter int unsigned DATA_WIDTH    = ganmind_pkg::DATA_WIDTH,
  parameter int unsigned Q_FRAC        = ganmind_pkg::Q_FRAC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DATA_WIDTH*ELEMENT_COUNT-1:0] data_in,
  output logic [DATA_WIDTH*ELEMENT_COUNT-1:0] data_out,
  output logic                          done,
  output logic                          busy
);
  import ganmind_pkg::*;

  localparam int unsigned VW = DATA_WIDTH * ELEMENT_COUNT;
  localparam int unsigned CW = calc_clog2(ELEMENT_COUNT + 1);

  typedef logic [DATA_WIDTH:0] wide_t;

  localparam wide_t ONE  = wide_t'(1 << Q_FRAC);
  localparam wide_t HALF = wide_t'((1 << Q_FRAC) >> 1);
  localparam wide_t SAT  = wide_t'(5 << Q_FRAC);
  localparam wide_t T2   = wide_t'((19 << Q_FRAC) >> 3);
  localparam wide_t OFF2 = wide_t'((27 << Q_FRAC) >> 5);
  localparam wide_t OFF1 = wide_t'((5 << Q_FRAC) >> 3);

  logic [VW-1:0]         in_sr;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] y;

  // Evaluated on |x| in one extra bit so the most negative input negates cleanly
  function automatic logic [DATA_WIDTH-1:0] sig_pl(input logic [DATA_WIDTH-1:0] v);
    logic  neg;
    wide_t x, ax, p;
    neg = v[DATA_WIDTH-1];
    x   = {v[DATA_WIDTH-1], v};
    ax  = neg ? wide_t'(-x) : x;
    if (ax >= SAT)      p = ONE;
    else if (ax >= T2)  p = (ax >> 5) + OFF2;
    else if (ax >= ONE) p = (ax >> 3) + OFF1;
    else                p = (ax >> 2) + HALF;
    return DATA_WIDTH'(neg ? (ONE - p) : p);
  endfunction

  always_comb begin
    y = sig_pl(in_sr[DATA_WIDTH-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_sr    <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        in_sr <= data_in;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        // Results shift in from the top so element 0 lands at the bottom slot
        in_sr    <= in_sr >> DATA_WIDTH;
        data_out <= VW'({y, data_out} >> DATA_WIDTH);
        cnt      <= cnt + 1'b1;
        if (cnt == CW'(ELEMENT_COUNT - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sigmoid_share_arbiter.sv
// Round-robin front end sharing one vector_sigmoid engine among NUM_REQ
// requesters; the winner's vector is buffered so the requester is freed at ack.
module sigmoid_share_arbiter #(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned ELEMENT_COUNT = 128,
  parameter int unsigned DATA_WIDTH    = ganmind_pkg::DATA_WIDTH,
  parameter int unsigned Q_FRAC        = ganmind_pkg::Q_FRAC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sigmoid_share_arbiter_if.slave bus
);
  import ganmind_pkg::*;

  localparam int unsigned GW = calc_clog2(NUM_REQ);
  localparam int unsigned VW = DATA_WIDTH * ELEMENT_COUNT;

  state_e        state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] winner;
  logic [VW-1:0] vec_buf;
  logic [VW-1:0] winner_vec;
  logic [VW-1:0] eng_out;
  logic          eng_rst;
  logic          eng_start;
  logic          eng_done;
  logic          eng_busy;
  logic          any_req;

  // First requester at or after last+1, wrapping
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [GW-1:0]      last);
    logic               found;
    logic [NUM_REQ-1:0] sh;
    int unsigned        idx;
    found   = 1'b0;
    rr_pick = last;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last) + k) % NUM_REQ;
      sh  = r >> idx;
      if (!found && sh[0]) begin
        found   = 1'b1;
        rr_pick = GW'(idx);
      end
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

  always_comb begin
    any_req    = |bus.req;
    winner     = rr_pick(bus.req, last_grant);
    winner_vec = VW'(bus.req_data >> (32'(winner) * VW));
    eng_rst    = ~rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      bus.ack        <= '0;
      bus.resp_valid <= '0;
      bus.resp_data  <= '0;
      bus.busy       <= 1'b0;
      bus.grant_id   <= '0;
      last_grant     <= GW'(NUM_REQ - 1);
      vec_buf        <= '0;
      eng_start      <= 1'b0;
    end else begin
      bus.ack        <= '0;
      bus.resp_valid <= '0;
      eng_start      <= 1'b0;
      case (state)
        // Buffer is captured at the grant edge, so ack (LOAD) already frees the requester
        ST_IDLE: if (any_req) begin
          vec_buf      <= winner_vec;
          bus.grant_id <= winner;
          bus.ack      <= onehot(winner);
          bus.busy     <= 1'b1;
          state        <= ST_LOAD;
        end
        ST_LOAD: if (!eng_busy) begin
          eng_start <= 1'b1;
          state     <= ST_START;
        end
        ST_START: state <= ST_RUN;
        ST_RUN: if (eng_done) begin
          bus.resp_data  <= eng_out;
          bus.resp_valid <= onehot(bus.grant_id);
          state          <= ST_RESP;
        end
        ST_RESP: begin
          last_grant <= bus.grant_id;
          bus.busy   <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  vector_sigmoid #(
    .ELEMENT_COUNT(ELEMENT_COUNT),
    .DATA_WIDTH   (DATA_WIDTH),
    .Q_FRAC       (Q_FRAC)
  ) u_engine (
    .clk     (clk),
    .rst     (eng_rst),
    .start   (eng_start),
    .data_in (vec_buf),
    .data_out(eng_out),
    .done    (eng_done),
    .busy    (eng_busy)
  );

endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// Bench for sigmoid_share_arbiter: random vectors against a plain-arithmetic
// PLAN sigmoid model and a round-robin winner model.
module tb_sigmoid_share_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned EC = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned VW = DW * EC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sigmoid_share_arbiter_if #(.NUM_REQ(NR), .ELEMENT_COUNT(EC), .DATA_WIDTH(DW)) bus ();

  sigmoid_share_arbiter #(
    .NUM_REQ(NR), .ELEMENT_COUNT(EC), .DATA_WIDTH(DW), .Q_FRAC(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int last_ref;
  logic [VW-1:0] vec [NR];

  // sigmoid(x) in Q8.8: 1 for |x|>=5, slopes 1/32, 1/8, 1/4 below, mirrored for x<0
  function automatic int sig_ref(input int x);
    int a, p;
    a = (x < 0) ? -x : x;
    if (a >= 1280)     p = 256;
    else if (a >= 608) p = a / 32 + 216;
    else if (a >= 256) p = a / 8 + 160;
    else               p = a / 4 + 128;
    return (x < 0) ? 256 - p : p;
  endfunction

  function automatic logic [VW-1:0] vec_ref(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic signed [DW-1:0] e;
    r = '0;
    for (int i = 0; i < int'(EC); i++) begin
      e = v[i*DW +: DW];
      r[i*DW +: DW] = DW'(sig_ref(int'(e)));
    end
    return r;
  endfunction

  function automatic int rr_ref(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= int'(NR); k++) begin
      if (r[(last + k) % int'(NR)]) return (last + k) % int'(NR);
    end
    return -1;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    int x;
    v = '0;
    for (int i = 0; i < int'(EC); i++) begin
      case ($urandom_range(0, 2))
        0:       x = int'($urandom_range(0, 65535)) - 32768;
        1:       x = int'($urandom_range(0, 2800)) - 1400;
        default: x = int'($urandom_range(0, 600)) - 300;
      endcase
      v[i*DW +: DW] = DW'(x);
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [VW-1:0] v);
    vec[i] = v;
    bus.req_data[i*VW +: VW] = v;
  endtask

  task automatic wait_ack(input int max, output int n, output logic [NR-1:0] a);
    n = 0;
    a = '0;
    for (int c = 1; c <= max; c++) begin
      step();
      if (bus.ack != '0) begin
        n = c;
        a = bus.ack;
        break;
      end
    end
  endtask

  task automatic watch(input int max, output int n, output logic [NR-1:0] rv,
                       output logic [VW-1:0] rd, output logic [NR-1:0] acks,
                       output logic clash);
    n = 0; rv = '0; rd = '0; acks = '0; clash = 1'b0;
    for (int c = 1; c <= max; c++) begin
      step();
      acks |= bus.ack;
      if (bus.ack != '0 && bus.resp_valid != '0) clash = 1'b1;
      if (bus.resp_valid != '0) begin
        n = c;
        rv = bus.resp_valid;
        rd = bus.resp_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '1;
    for (int i = 0; i < int'(NR); i++) set_vec(i, rand_vec());
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.ack !== '0 || bus.resp_valid !== '0 || bus.busy !== 1'b0 ||
          bus.grant_id !== '0 || bus.resp_data !== '0) begin
        errors++;
        $display("FAIL reset_outputs: ack=%b resp_valid=%b busy=%b grant_id=%0d resp_data=%h, all required 0",
                 bus.ack, bus.resp_valid, bus.busy, bus.grant_id, bus.resp_data);
      end
    end
    rst_n = 1'b1;
    bus.req = '0;
    last_ref = NR - 1;
  endtask

  task automatic test_single();
    int n, w; logic [NR-1:0] a, rv, acks; logic [VW-1:0] rd; logic clash;
    set_vec(1, '0);
    bus.req = 3'b010;
    w = rr_ref(bus.req, last_ref);
    wait_ack(10, n, a);
    checks++;
    if (n !== 1 || a !== NR'(1) << w || bus.grant_id !== 2'(w) || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_ack: after %0d cycles ack=%b grant_id=%0d busy=%b, required 1 cycle ack=%b grant_id=%0d busy=1",
               n, a, bus.grant_id, bus.busy, NR'(1) << w, w);
    end
    bus.req = '0;
    watch(20, n, rv, rd, acks, clash);
    checks++;
    if (n + 1 !== int'(EC) + 4 || rv !== NR'(1) << w || bus.busy !== 1'b1 || acks !== '0) begin
      errors++;
      $display("FAIL single_resp: resp_valid=%b at req+%0d busy=%b extra_acks=%b, required %b at req+%0d busy=1",
               rv, n + 1, bus.busy, acks, NR'(1) << w, EC + 4);
    end
    checks++;
    if (rd !== {EC{16'h0080}} || rd !== vec_ref(vec[1])) begin
      errors++;
      $display("FAIL single_data: resp_data=%h required %h", rd, {EC{16'h0080}});
    end
    last_ref = w;
    step();
    checks++;
    if (bus.resp_valid !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after: resp_valid=%b busy=%b, required 0 and 0", bus.resp_valid, bus.busy);
    end
  endtask

  task automatic test_simultaneous();
    int n, w; logic [NR-1:0] a, rv, acks; logic [VW-1:0] rd, latched; logic clash;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    last_ref = NR - 1;
    for (int i = 0; i < int'(NR); i++) set_vec(i, rand_vec());
    set_vec(2, {16'h8000, 16'h0500, 16'h025F, 16'hFF00});
    bus.req = '1;
    for (int job = 0; job < 4; job++) begin
      w = rr_ref(bus.req, last_ref);
      wait_ack(12, n, a);
      checks++;
      if (a !== NR'(1) << w || (job > 0 && n !== 2) || bus.grant_id !== 2'(w)) begin
        errors++;
        $display("FAIL simul_ack%0d: ack=%b after %0d cycles grant_id=%0d, required ack=%b grant_id=%0d (2 cycles after previous resp)",
                 job, a, n, bus.grant_id, NR'(1) << w, w);
      end
      latched = vec[w];
      bus.req[w] = 1'b0;
      step();
      set_vec(w, rand_vec());
      if (job < 3) bus.req[w] = 1'b1;
      watch(20, n, rv, rd, acks, clash);
      if (job == 3) bus.req = '0;
      checks++;
      if (n !== int'(EC) + 2 || rv !== NR'(1) << w || clash !== 1'b0 || acks !== '0) begin
        errors++;
        $display("FAIL simul_resp%0d: resp_valid=%b at ack+%0d clash=%b extra_acks=%b, required %b at ack+%0d",
                 job, rv, n + 1, clash, acks, NR'(1) << w, EC + 3);
      end
      checks++;
      if (rd !== vec_ref(latched)) begin
        errors++;
        $display("FAIL simul_data%0d: resp_data=%h required %h", job, rd, vec_ref(latched));
      end
      last_ref = w;
    end
    step(); step();
  endtask

  task automatic test_isolation();
    int n; logic [NR-1:0] a; logic [VW-1:0] rd, latched;
    set_vec(0, rand_vec());
    bus.req = 3'b001;
    wait_ack(10, n, a);
    checks++;
    if (a !== 3'b001 || n !== 1) begin
      errors++;
      $display("FAIL iso_ack: ack=%b after %0d cycles, required 001 after 1", a, n);
    end
    latched = vec[0];
    bus.req = '0;
    step();
    n = 0; rd = '0;
    for (int c = 1; c <= 20; c++) begin
      set_vec(0, rand_vec());
      step();
      if (bus.resp_valid != '0) begin
        n = c;
        rd = bus.resp_data;
        break;
      end
    end
    checks++;
    if (n == 0 || rd !== vec_ref(latched)) begin
      errors++;
      $display("FAIL iso_data: resp seen=%0d resp_data=%h required %h", n != 0, rd, vec_ref(latched));
    end
    last_ref = 0;
    step();
  endtask

  task automatic test_late_arrival();
    int n, w; logic [NR-1:0] a, rv, acks; logic [VW-1:0] rd, latched; logic clash;
    set_vec(0, rand_vec());
    bus.req = 3'b001;
    wait_ack(10, n, a);
    latched = vec[0];
    bus.req = '0;
    step(); step();
    set_vec(2, rand_vec());
    bus.req[2] = 1'b1;
    watch(20, n, rv, rd, acks, clash);
    checks++;
    if (rv !== 3'b001 || rd !== vec_ref(latched) || acks !== '0) begin
      errors++;
      $display("FAIL late_first: resp_valid=%b resp_data=%h acks=%b, required 001 %h no ack",
               rv, rd, acks, vec_ref(latched));
    end
    last_ref = 0;
    w = rr_ref(bus.req, last_ref);
    wait_ack(10, n, a);
    checks++;
    if (a !== NR'(1) << w || n !== 2) begin
      errors++;
      $display("FAIL late_ack: ack=%b %0d cycles after resp, required %b after 2", a, n, NR'(1) << w);
    end
    latched = vec[2];
    bus.req = '0;
    watch(20, n, rv, rd, acks, clash);
    checks++;
    if (rv !== 3'b100 || rd !== vec_ref(latched)) begin
      errors++;
      $display("FAIL late_second: resp_valid=%b resp_data=%h, required 100 %h", rv, rd, vec_ref(latched));
    end
    last_ref = w;
    step();
  endtask

  task automatic test_reset_mid_job();
    int n, w; logic [NR-1:0] a, rv, acks; logic [VW-1:0] rd, latched; logic clash;
    set_vec(1, rand_vec());
    bus.req = 3'b010;
    wait_ack(10, n, a);
    bus.req = '0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.resp_valid !== '0 || bus.ack !== '0 || bus.resp_data !== '0) begin
      errors++;
      $display("FAIL midreset_state: busy=%b resp_valid=%b ack=%b resp_data=%h, required all 0",
               bus.busy, bus.resp_valid, bus.ack, bus.resp_data);
    end
    rst_n = 1'b1;
    last_ref = NR - 1;
    watch(EC + 8, n, rv, rd, acks, clash);
    checks++;
    if (n !== 0 || acks !== '0) begin
      errors++;
      $display("FAIL midreset_quiet: resp_valid=%b at cycle %0d acks=%b, required none", rv, n, acks);
    end
    set_vec(0, rand_vec());
    bus.req = 3'b001;
    w = rr_ref(bus.req, last_ref);
    wait_ack(10, n, a);
    latched = vec[0];
    bus.req = '0;
    watch(20, n, rv, rd, acks, clash);
    checks++;
    if (a !== NR'(1) << w || rv !== NR'(1) << w || n !== int'(EC) + 3 || rd !== vec_ref(latched)) begin
      errors++;
      $display("FAIL midreset_next: ack=%b resp_valid=%b at ack+%0d data=%h, required %b %b ack+%0d %h",
               a, rv, n, rd, NR'(1) << w, NR'(1) << w, EC + 3, vec_ref(latched));
    end
    last_ref = w;
    step();
  endtask

  task automatic test_withdrawn();
    int n; logic [NR-1:0] a, rv, acks; logic [VW-1:0] rd, latched; logic clash;
    set_vec(0, rand_vec());
    set_vec(1, rand_vec());
    bus.req = 3'b001;
    wait_ack(10, n, a);
    latched = vec[0];
    bus.req = '0;
    step(); step();
    bus.req[1] = 1'b1;
    step();
    bus.req[1] = 1'b0;
    watch(20, n, rv, rd, acks, clash);
    checks++;
    if (rv !== 3'b001 || acks !== '0 || rd !== vec_ref(latched)) begin
      errors++;
      $display("FAIL withdrawn_job: resp_valid=%b acks=%b data=%h, required 001 no ack %h",
               rv, acks, rd, vec_ref(latched));
    end
    watch(EC + 8, n, rv, rd, acks, clash);
    checks++;
    if (n !== 0 || acks !== '0) begin
      errors++;
      $display("FAIL withdrawn_quiet: resp_valid=%b acks=%b, required none for requester 1", rv, acks);
    end
  endtask

  initial begin
    bus.req = '0;
    bus.req_data = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_isolation();
    test_late_arrival();
    test_reset_mid_job();
    test_withdrawn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
